// File: rtl/axis_residual_packer_32.sv
// AXI-Stream byte packer: squeezes MSB-aligned partial beats into full 32-bit beats,
// carrying leftover bytes in a residual register between beats.
module axis_residual_packer_32 #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out
);

  typedef enum logic {PACK, FLUSH} state_e;

  state_e                  state_q, state_d;
  logic [DATA_WD-1:0]      resData_q, resData_d;
  logic [BYTE_CNT_WD-1:0]  resCnt_q, resCnt_d;
  logic                    valid_q, valid_d;
  logic [DATA_WD-1:0]      data_q, data_d;
  logic [DATA_BYTE_WD-1:0] keep_q, keep_d;
  logic                    last_q, last_d;

  logic                    outFree;
  logic                    accept;
  logic [BYTE_CNT_WD:0]    inCnt;
  logic [BYTE_CNT_WD:0]    total;
  logic [DATA_WD-1:0]      inMasked;
  logic [2*DATA_WD-1:0]    merged;

  function automatic logic [DATA_BYTE_WD-1:0] keepMask(input logic [BYTE_CNT_WD:0] n);
    case (n)
      3'd0:    keepMask = 4'b0000;
      3'd1:    keepMask = 4'b1000;
      3'd2:    keepMask = 4'b1100;
      3'd3:    keepMask = 4'b1110;
      default: keepMask = 4'b1111;
    endcase
  endfunction

  function automatic logic [DATA_WD-1:0] byteMask(input logic [DATA_BYTE_WD-1:0] k);
    byteMask = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) byteMask[8*i +: 8] = {8{k[i]}};
  endfunction

  assign outFree = !valid_q || ready_out;
  assign accept  = valid_in && ready_in;

  // A non-contiguous keep is treated as "top c bytes", so mask by count, not by keep itself.
  always_comb begin
    inCnt    = (BYTE_CNT_WD+1)'($countones(keep_in));
    total    = {1'b0, resCnt_q} + inCnt;
    inMasked = data_in & byteMask(keepMask(inCnt));
    merged   = {resData_q, {DATA_WD{1'b0}}} |
               ({inMasked, {DATA_WD{1'b0}}} >> {resCnt_q, 3'b000});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= PACK;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      PACK:  if (accept && last_in && total > 3'd4) state_d = FLUSH;
      FLUSH: if (outFree) state_d = PACK;
      default: state_d = PACK;
    endcase
  end

  always_comb begin
    ready_in = !rst && (state_q == PACK) && outFree;
  end

  always_comb begin
    resData_d = resData_q;
    resCnt_d  = resCnt_q;
    valid_d   = valid_q;
    data_d    = data_q;
    keep_d    = keep_q;
    last_d    = last_q;
    if (state_q == FLUSH) begin
      if (outFree) begin
        valid_d   = 1'b1;
        data_d    = resData_q;
        keep_d    = keepMask({1'b0, resCnt_q});
        last_d    = 1'b1;
        resData_d = '0;
        resCnt_d  = '0;
      end
    end else if (accept) begin
      if (!last_in && total < 3'd4) begin
        resData_d = merged[2*DATA_WD-1:DATA_WD];
        resCnt_d  = total[BYTE_CNT_WD-1:0];
        valid_d   = 1'b0;
      end else if (!last_in || total > 3'd4) begin
        valid_d   = 1'b1;
        data_d    = merged[2*DATA_WD-1:DATA_WD];
        keep_d    = '1;
        last_d    = 1'b0;
        resData_d = merged[DATA_WD-1:0];
        resCnt_d  = BYTE_CNT_WD'(total - 3'd4);
      end else begin
        // Includes t=0: an empty last beat still goes out to mark the packet end.
        valid_d   = 1'b1;
        data_d    = merged[2*DATA_WD-1:DATA_WD];
        keep_d    = keepMask(total);
        last_d    = 1'b1;
        resData_d = '0;
        resCnt_d  = '0;
      end
    end else if (outFree) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resData_q <= '0;
      resCnt_q  <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      keep_q    <= '0;
      last_q    <= 1'b0;
    end else begin
      resData_q <= resData_d;
      resCnt_q  <= resCnt_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      keep_q    <= keep_d;
      last_q    <= last_d;
    end
  end

  assign valid_out = valid_q;
  assign data_out  = data_q;
  assign keep_out  = keep_q;
  assign last_out  = last_q;

endmodule

// File: tb/tb_axis_residual_packer_32.sv
// Bench for axis_residual_packer_32: directed scenarios plus a randomized run
// compared against a byte-queue packet model.
module tb_axis_residual_packer_32;

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic [31:0] data_in;
  logic [3:0]  keep_in;
  logic        last_in;
  logic        ready_in;
  logic        valid_out;
  logic [31:0] data_out;
  logic [3:0]  keep_out;
  logic        last_out;
  logic        ready_out;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  axis_residual_packer_32 dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .keep_in   (keep_in),
    .last_in   (last_in),
    .ready_in  (ready_in),
    .valid_out (valid_out),
    .data_out  (data_out),
    .keep_out  (keep_out),
    .last_out  (last_out),
    .ready_out (ready_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Presents one beat just after a rising edge and holds it until it is accepted.
  task automatic sendBeat(input logic [31:0] d, input logic [3:0] k, input logic l);
    int n = 0;
    @(posedge clk); #1;
    valid_in = 1'b1; data_in = d; keep_in = k; last_in = l;
    @(negedge clk);
    while (!ready_in && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!ready_in) begin
      checks++; errors++;
      $display("[TB] FAIL send_timeout: ready_in=%0b required 1", ready_in);
    end
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (valid_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b want 0", valid_out); end
    checks++; if (data_out !== 32'h0) begin errors++; $display("[TB] FAIL reset_data: got %h want 0", data_out); end
    checks++; if (keep_out !== 4'h0) begin errors++; $display("[TB] FAIL reset_keep: got %b want 0000", keep_out); end
    checks++; if (last_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_last: got %0b want 0", last_out); end
    checks++; if (ready_in !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready_in: got %0b want 0", ready_in); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single();
    @(posedge clk); #1;
    valid_in = 1'b1; data_in = 32'h11223344; keep_in = 4'hF; last_in = 1'b1;
    @(negedge clk);
    checks++; if (ready_in !== 1'b1) begin errors++; $display("[TB] FAIL single_ready: got %0b want 1", ready_in); end
    @(posedge clk); #1;
    valid_in = 1'b0;
    @(negedge clk);
    checks++;
    if (valid_out !== 1'b1 || data_out !== 32'h11223344 || keep_out !== 4'hF || last_out !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_out: got v=%0b %h/%b/%0b want 1 11223344/1111/1", valid_out, data_out, keep_out, last_out);
    end
  endtask

  task automatic test_carry();
    sendBeat(32'hAABB0000, 4'hC, 1'b0);
    @(negedge clk);
    checks++; if (valid_out !== 1'b0) begin errors++; $display("[TB] FAIL carry_no_out: got %0b want 0", valid_out); end
    sendBeat(32'hCCDDEEFF, 4'hF, 1'b1);
    @(negedge clk);
    checks++;
    if (valid_out !== 1'b1 || data_out !== 32'hAABBCCDD || keep_out !== 4'hF || last_out !== 1'b0 || ready_in !== 1'b0) begin
      errors++;
      $display("[TB] FAIL carry_first: got v=%0b %h/%b/%0b rdy=%0b want 1 AABBCCDD/1111/0 rdy=0", valid_out, data_out, keep_out, last_out, ready_in);
    end
    @(negedge clk);
    checks++;
    if (valid_out !== 1'b1 || data_out !== 32'hEEFF0000 || keep_out !== 4'hC || last_out !== 1'b1 || ready_in !== 1'b1) begin
      errors++;
      $display("[TB] FAIL carry_flush: got v=%0b %h/%b/%0b rdy=%0b want 1 EEFF0000/1100/1 rdy=1", valid_out, data_out, keep_out, last_out, ready_in);
    end
  endtask

  task automatic test_accumulate();
    sendBeat(32'h11000000, 4'h8, 1'b0);
    @(negedge clk);
    checks++; if (valid_out !== 1'b0) begin errors++; $display("[TB] FAIL accum_idle1: got %0b want 0", valid_out); end
    sendBeat(32'h22000000, 4'h8, 1'b0);
    @(negedge clk);
    checks++; if (valid_out !== 1'b0) begin errors++; $display("[TB] FAIL accum_idle2: got %0b want 0", valid_out); end
    sendBeat(32'h33440000, 4'hC, 1'b1);
    @(negedge clk);
    checks++;
    if (valid_out !== 1'b1 || data_out !== 32'h11223344 || keep_out !== 4'hF || last_out !== 1'b1) begin
      errors++;
      $display("[TB] FAIL accum_out: got v=%0b %h/%b/%0b want 1 11223344/1111/1", valid_out, data_out, keep_out, last_out);
    end
  endtask

  task automatic test_empty_last();
    sendBeat(32'h55660000, 4'hC, 1'b0);
    sendBeat(32'h0, 4'h0, 1'b1);
    @(negedge clk);
    checks++;
    if (valid_out !== 1'b1 || data_out !== 32'h55660000 || keep_out !== 4'hC || last_out !== 1'b1) begin
      errors++;
      $display("[TB] FAIL empty_resid: got v=%0b %h/%b/%0b want 1 55660000/1100/1", valid_out, data_out, keep_out, last_out);
    end
    sendBeat(32'hDEADBEEF, 4'h0, 1'b1);
    @(negedge clk);
    checks++;
    if (valid_out !== 1'b1 || data_out !== 32'h0 || keep_out !== 4'h0 || last_out !== 1'b1) begin
      errors++;
      $display("[TB] FAIL empty_bare: got v=%0b %h/%b/%0b want 1 00000000/0000/1", valid_out, data_out, keep_out, last_out);
    end
  endtask

  task automatic test_back_pressure();
    @(posedge clk); #1;
    ready_out = 1'b0;
    sendBeat(32'h01020304, 4'hF, 1'b0);
    valid_in = 1'b1; data_in = 32'hA1B2C3D4; keep_in = 4'hF; last_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (valid_out !== 1'b1 || data_out !== 32'h01020304 || keep_out !== 4'hF || last_out !== 1'b0 || ready_in !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_hold%0d: got v=%0b %h/%b/%0b rdy=%0b want 1 01020304/1111/0 rdy=0", i, valid_out, data_out, keep_out, last_out, ready_in);
      end
    end
    @(posedge clk); #1;
    ready_out = 1'b1;
    @(negedge clk);
    checks++; if (ready_in !== 1'b1) begin errors++; $display("[TB] FAIL bp_release_ready: got %0b want 1", ready_in); end
    @(posedge clk); #1;
    valid_in = 1'b0;
    @(negedge clk);
    checks++;
    if (valid_out !== 1'b1 || data_out !== 32'hA1B2C3D4 || keep_out !== 4'hF || last_out !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_next: got v=%0b %h/%b/%0b want 1 A1B2C3D4/1111/1", valid_out, data_out, keep_out, last_out);
    end
    @(negedge clk);
    checks++; if (valid_out !== 1'b0) begin errors++; $display("[TB] FAIL bp_no_dup: got %0b want 0", valid_out); end
  endtask

  task automatic test_reset_mid_packet();
    sendBeat(32'h77880000, 4'hC, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (valid_out !== 1'b0 || data_out !== 32'h0 || keep_out !== 4'h0 || last_out !== 1'b0 || ready_in !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrst_zero: got v=%0b %h/%b/%0b rdy=%0b want all 0", valid_out, data_out, keep_out, last_out, ready_in);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    sendBeat(32'h99AABBCC, 4'hF, 1'b1);
    @(negedge clk);
    checks++;
    if (valid_out !== 1'b1 || data_out !== 32'h99AABBCC || keep_out !== 4'hF || last_out !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midrst_out: got v=%0b %h/%b/%0b want 1 99AABBCC/1111/1", valid_out, data_out, keep_out, last_out);
    end
    @(negedge clk);
    checks++; if (valid_out !== 1'b0) begin errors++; $display("[TB] FAIL midrst_only: got %0b want 0", valid_out); end
  endtask

  // Random packets with random gaps and back-pressure; the model just regroups each packet's bytes into 4s.
  task automatic test_random_stream();
    beat_t       stimQ[$];
    beat_t       expQ[$];
    logic [7:0]  pktQ[$];
    beat_t       b, e;
    int          idx = 0;
    int          cyc = 0;
    logic [3:0]  contig[4];
    contig[0] = 4'hF; contig[1] = 4'hE; contig[2] = 4'hC; contig[3] = 4'h8;
    for (int p = 0; p < 60; p++) begin
      int len = $urandom_range(1, 5);
      for (int i = 0; i < len; i++) begin
        int r = $urandom_range(0, 9);
        b.d = $urandom;
        b.l = (i == len - 1);
        if (r == 9) b.k = 4'($urandom_range(1, 15));
        else if (b.l && r == 8) b.k = 4'h0;
        else b.k = contig[r % 4];
        stimQ.push_back(b);
      end
    end
    while ((idx < stimQ.size() || expQ.size() > 0) && cyc < 20000) begin
      @(posedge clk); #1;
      if (idx < stimQ.size() && ($urandom % 4) != 0) begin
        valid_in = 1'b1; data_in = stimQ[idx].d; keep_in = stimQ[idx].k; last_in = stimQ[idx].l;
      end else begin
        valid_in = 1'b0;
      end
      ready_out = (($urandom % 3) != 0);
      @(negedge clk);
      if (valid_out && ready_out) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL rand_extra: got %h/%b/%0b want no beat", data_out, keep_out, last_out);
        end else begin
          e = expQ.pop_front();
          if (data_out !== e.d || keep_out !== e.k || last_out !== e.l) begin
            errors++;
            $display("[TB] FAIL rand_beat: got %h/%b/%0b want %h/%b/%0b", data_out, keep_out, last_out, e.d, e.k, e.l);
          end
        end
      end
      if (valid_in && ready_in) begin
        b = stimQ[idx];
        idx++;
        for (int j = 0; j < $countones(b.k); j++) pktQ.push_back(b.d[31-8*j -: 8]);
        if (!b.l) begin
          if (pktQ.size() >= 4) begin
            e.d = 32'h0;
            for (int j = 0; j < 4; j++) e.d[31-8*j -: 8] = pktQ.pop_front();
            e.k = 4'hF; e.l = 1'b0;
            expQ.push_back(e);
          end
        end else if (pktQ.size() == 0) begin
          e.d = 32'h0; e.k = 4'h0; e.l = 1'b1;
          expQ.push_back(e);
        end else begin
          while (pktQ.size() > 0) begin
            int n = (pktQ.size() > 4) ? 4 : pktQ.size();
            e.d = 32'h0;
            for (int j = 0; j < n; j++) e.d[31-8*j -: 8] = pktQ.pop_front();
            e.k = 4'hF << (4 - n);
            e.l = (pktQ.size() == 0);
            expQ.push_back(e);
          end
        end
      end
      cyc++;
    end
    checks++;
    if (idx != stimQ.size() || expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL rand_drain: sent %0d of %0d, pending %0d want all sent and 0 pending", idx, stimQ.size(), expQ.size());
    end
    @(posedge clk); #1;
    valid_in = 1'b0;
    ready_out = 1'b1;
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0; ready_out = 1'b1;
    test_reset();
    test_single();
    test_carry();
    test_accumulate();
    test_empty_last();
    test_back_pressure();
    test_reset_mid_packet();
    test_random_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
